// File: rtl/prco_uart_loader_pkg.sv
// rtl/prco_uart_loader_pkg.sv - shared state encodings and frame constants for the UART image loader
package prco_uart_loader_pkg;

  typedef enum logic [3:0] {
    ST_SYNC   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_CSUM   = 4'd5,
    ST_WRITE  = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
  } loader_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Order in which the fields of one frame arrive on the rx stream.
  typedef enum logic [2:0] {
    FLD_SYNC    = 3'd0,
    FLD_LEN_HI  = 3'd1,
    FLD_LEN_LO  = 3'd2,
    FLD_DATA_HI = 3'd3,
    FLD_DATA_LO = 3'd4,
    FLD_CSUM    = 3'd5
  } frame_field_e;

  function automatic logic is_rx_state(input loader_state_e s);
    return s inside {ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_CSUM};
  endfunction

endpackage

// File: rtl/prco_loader_timeout.sv
// rtl/prco_loader_timeout.sv - inter-byte idle watchdog: reloads on clear, pulses expiry after the idle budget
module prco_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic q_expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Held at the reload value while idle so every run starts from a full budget.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_clear || !i_run) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign q_expire = i_run && (count == '0);

endmodule

// File: rtl/prco_uart_loader.sv
// rtl/prco_uart_loader.sv - boot loader: pulls a framed image from the UART rx FIFO into local memory
// Optional trailing XOR checksum byte enabled by PRCO_LOADER_CHECKSUM_EN.
module prco_uart_loader
  import prco_uart_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = 256,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_fifo_empty,
  output logic        q_rx_fifo_pop,
  output logic        q_mem_we,
  output logic [15:0] q_mem_addr,
  output logic [15:0] q_mem_din,
  output logic        q_core_reset,
  output logic        q_busy,
  output logic        q_done,
  output logic        q_error
);

`ifdef PRCO_LOADER_CHECKSUM_EN
  localparam loader_state_e ST_FRAME_END = ST_CSUM;
`else
  localparam loader_state_e ST_FRAME_END = ST_DONE;
`endif

  loader_state_e state, state_nx;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [15:0] length;
  logic [15:0] word_cnt;
  logic [15:0] word_cnt_inc;
  logic [15:0] len_now;
  logic        pop;
  logic        run;
  logic        expire;
  logic        sync_hit;

`ifdef PRCO_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  // Gated by reset so the FIFO is never drained while reset is held.
  assign pop          = i_reset_n && is_rx_state(state) && !i_rx_fifo_empty;
  assign run          = !(state inside {ST_SYNC, ST_DONE, ST_ERROR});
  assign sync_hit     = (i_rx_byte == SYNC_BYTE);
  assign len_now      = {len_hi, i_rx_byte};
  assign word_cnt_inc = word_cnt + 16'd1;

  prco_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (pop),
    .i_run     (run),
    .q_expire  (expire)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_SYNC:   if (pop && sync_hit) state_nx = ST_LEN_HI;
      ST_LEN_HI: if (pop) state_nx = ST_LEN_LO;
      ST_LEN_LO: begin
        if (pop) begin
          if (len_now == 16'd0) begin
            state_nx = ST_FRAME_END;
          end else if (32'(len_now) > MAX_WORDS) begin
            state_nx = ST_ERROR;
          end else begin
            state_nx = ST_DAT_HI;
          end
        end
      end
      ST_DAT_HI: if (pop) state_nx = ST_DAT_LO;
      ST_DAT_LO: if (pop) state_nx = ST_WRITE;
      ST_WRITE:  state_nx = (word_cnt_inc == length) ? ST_FRAME_END : ST_DAT_HI;
`ifdef PRCO_LOADER_CHECKSUM_EN
      ST_CSUM:   if (pop) state_nx = (i_rx_byte == csum) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:   state_nx = ST_DONE;
      ST_ERROR:  state_nx = ST_SYNC;
      default:   state_nx = ST_SYNC;
    endcase
    // A stalled sender wins over a byte that happens to land on the expiry cycle.
    if (expire) state_nx = ST_ERROR;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_SYNC;
      len_hi     <= '0;
      data_hi    <= '0;
      length     <= '0;
      word_cnt   <= '0;
      q_mem_addr <= '0;
      q_mem_din  <= '0;
      q_error    <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        case (state)
          ST_SYNC:   if (sync_hit) word_cnt <= '0;
          ST_LEN_HI: len_hi <= i_rx_byte;
          ST_LEN_LO: length <= len_now;
          ST_DAT_HI: data_hi <= i_rx_byte;
          ST_DAT_LO: begin
            q_mem_din  <= {data_hi, i_rx_byte};
            q_mem_addr <= word_cnt;
          end
          default: ;
        endcase
      end
      if (state == ST_WRITE) word_cnt <= word_cnt_inc;
      // Error is sticky across the return to SYNC; only a successful load clears it.
      if (state_nx == ST_ERROR) begin
        q_error <= 1'b1;
      end else if (state_nx == ST_DONE) begin
        q_error <= 1'b0;
      end
    end
  end

`ifdef PRCO_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      csum <= '0;
    end else if (pop) begin
      case (state)
        ST_SYNC: if (sync_hit) csum <= '0;
        ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO: csum <= csum ^ i_rx_byte;
        default: ;
      endcase
    end
  end
`endif

  assign q_rx_fifo_pop = pop;
  assign q_mem_we      = (state == ST_WRITE);
  assign q_busy        = run;
  assign q_done        = (state == ST_DONE);
  assign q_core_reset  = (state != ST_DONE);

endmodule

// File: doc/prco_uart_loader.md
PRCO_UART_LOADER -- requirements
Module: prco_uart_loader

Interface
REQ-001 Parameters (name, default, meaning):
  - MAX_WORDS, 256, largest accepted image in 16-bit words.
  - SYNC_BYTE, 8'hA5, frame start marker.
  - TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes inside a frame.
REQ-002 Ports (name, direction, width, meaning):
  - i_clk, in, 1, single clock; all logic is on the rising edge.
  - i_reset_n, in, 1, reset, asynchronous and active-low.
  - i_rx_byte, in, 8, head of the UART rx FIFO (first-word fall-through).
  - i_rx_fifo_empty, in, 1, rx FIFO holds no byte.
  - q_rx_fifo_pop, out, 1, consume the head byte this cycle.
  - q_mem_we, out, 1, local-memory write strobe.
  - q_mem_addr, out, 16, word address of the write.
  - q_mem_din, out, 16, write data.
  - q_core_reset, out, 1, holds the core in reset while high.
  - q_busy, out, 1, a frame is in progress.
  - q_done, out, 1, image loaded and core released.
  - q_error, out, 1, last frame rejected.

Function
REQ-003 Frame format: SYNC_BYTE, LEN_HI, LEN_LO (length in words), then per word DATA_HI then DATA_LO, then CSUM (checksum only when the macro in REQ-016 is defined).
REQ-004 FSM states: SYNC, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM, WRITE, DONE, ERROR.
REQ-005 Pop handshake: q_rx_fifo_pop = !i_rx_fifo_empty while in SYNC, LEN_HI, LEN_LO, DAT_HI, DAT_LO or CSUM; i_rx_byte is sampled in the same cycle; back-to-back pops allowed.
REQ-006 SYNC: a byte equal to SYNC_BYTE moves to LEN_HI and clears the word counter and checksum; any other byte is popped and discarded.
REQ-007 LEN_LO: routing depends on the 16-bit length.
  - Length 0: go to CSUM, or to DONE when checksum is disabled.
  - Length > MAX_WORDS: go to ERROR.
  - Otherwise: go to DAT_HI.
REQ-008 DAT_LO, on consuming the low byte: latch {hi,lo} into q_mem_din and the word counter into q_mem_addr, then enter WRITE.
REQ-009 WRITE: q_mem_we=1 for exactly one cycle with no pop, then increment the word counter.
  - Counter reaches length: go to CSUM, or to DONE when checksum is disabled.
  - Otherwise: go to DAT_HI.
REQ-010 q_mem_we is 0 in every state other than WRITE; addresses run 0..length-1 with no wrap.
REQ-011 Timeout counter: clears on every pop and runs only outside SYNC/DONE/ERROR. Reaching TIMEOUT_CYCLES-1 enters ERROR, which takes priority over a byte arriving in the same cycle.
REQ-012 ERROR: q_error=1 and q_core_reset=1, then return to SYNC on the next cycle. q_error stays sticky until the next entry to DONE; a fresh SYNC_BYTE restarts loading.
REQ-013 DONE (terminal until reset):
  - q_core_reset=0, q_done=1, q_rx_fifo_pop=0.
  - Later rx bytes are left in the FIFO for the core.
REQ-014 q_busy=1 in every state except SYNC, DONE and ERROR.

Reset
REQ-015 Asserting i_reset_n low, including mid-frame, immediately forces:
  - state SYNC; all counters and the checksum to 0;
  - q_core_reset=1; q_rx_fifo_pop, q_mem_we, q_mem_addr, q_mem_din, q_busy, q_done and q_error to 0.
  Any partial image is abandoned.

Configuration
REQ-016 Macro PRCO_LOADER_CHECKSUM_EN controls the checksum.
  - Defined: the checksum is the XOR of LEN_HI, LEN_LO and every data byte. A CSUM byte equal to it enters DONE; a mismatching byte enters ERROR.
  - Undefined: the CSUM state and checksum register are absent; the last WRITE (or a length of 0) enters DONE directly.

Structure
REQ-017 A shared package/include holds:
  - the FSM state encodings;
  - the default SYNC_BYTE constant;
  - frame field order constants.
REQ-018 One sub-module, prco_loader_timeout: a loadable down-counter with clear and expiry pulse.

Verification
REQ-019 Bytes A5 00 02 12 34 56 78 plus CSUM 0x0A (XOR of 00,02,12,34,56,78) -> writes addr0=0x1234 and addr1=0x5678, one q_mem_we cycle each; then q_done=1 and q_core_reset=0.
REQ-020 Bytes 00 FF A5 00 00 plus CSUM 00 -> the first two bytes are discarded, there are no writes, q_done=1.
REQ-021 Bytes A5 01 01 (257 words, MAX_WORDS=256) -> ERROR, q_error=1, q_core_reset stays 1, and a subsequent valid frame loads with q_error cleared at DONE.
REQ-022 Bytes A5 00 01 12, then the FIFO stays empty for TIMEOUT_CYCLES -> ERROR with no write.
REQ-023 i_reset_n pulsed low after DAT_HI of word 3 -> all outputs return to reset values asynchronously, and a fresh frame loads from addr 0.
REQ-024 Bytes A5 00 01 AB CD plus CSUM 0x00 with checksum enabled -> one write, then ERROR. With the macro undefined, the same first five bytes -> DONE and the 0x00 byte is left in the FIFO.
